// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory for the fetch stage.
// Synchronous-read RAM image with fetch stall/valid handling, address-fault
// detection, and a byte-serial program-load port that assembles little-endian
// words and writes them sequentially from word 0.
module inst_mem_loadable #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = '0,
  parameter bit                    CHECK_RANGE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic                  FetchEn,
  input  logic                  Stall,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  InstValid,
  output logic                  AddrFault,
  input  logic                  LoadStart,
  input  logic [7:0]            LoadByte,
  input  logic                  LoadByteValid,
  output logic                  Loading,
  output logic                  LoadDone,
  output logic [ADDR_WIDTH:0]   LoadCount
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PH_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [PH_W-1:0]     LAST_PH  = PH_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Fault: misaligned, or (when range checking) any address bit above the image.
  function automatic logic fetch_fault(input logic [31:0] a);
    logic hi;
    hi = ((a >> (ADDR_WIDTH + 2)) != 32'd0);
    return (a[1:0] != 2'b00) || (CHECK_RANGE && hi);
  endfunction

  logic [DATA_WIDTH-1:0] mem_p1 [DEPTH];

  state_t                ld_state;
  logic [PH_W-1:0]       ld_phase;
  logic [DATA_WIDTH-1:0] ld_asm;
  logic [ADDR_WIDTH:0]   ld_count;
  logic                  ld_loading;
  logic                  ld_done;

  logic [DATA_WIDTH-1:0] instr_p1;
  logic                  vld_p1;
  logic                  fault_p1;

  logic [DATA_WIDTH-1:0] wr_word_p0;
  logic                  byte_take_p0;
  logic                  word_wr_p0;
  logic                  fault_p0;
  logic [ADDR_WIDTH-1:0] rd_idx_p0;

  // ---- stage p0: byte merge, write decision, fetch address decode ----
  always_comb begin
    wr_word_p0                  = ld_asm;
    wr_word_p0[8*ld_phase +: 8] = LoadByte;
    byte_take_p0 = (ld_state == ST_LOAD) && LoadByteValid && !LoadStart;
    word_wr_p0   = reset && byte_take_p0 && (ld_phase == LAST_PH);
    fault_p0     = fetch_fault(Address);
    rd_idx_p0    = Address[ADDR_WIDTH+1:2];
  end

  // ---- stage p1: memory array write (contents survive reset) ----
  always_ff @(posedge clk) begin
    if (word_wr_p0) begin
      mem_p1[ld_count[ADDR_WIDTH-1:0]] <= wr_word_p0;
    end
  end

  // ---- stage p1: RUN/LOAD control, registered fetch outputs ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      ld_state   <= ST_RUN;
      ld_phase   <= '0;
      ld_asm     <= '0;
      ld_count   <= '0;
      ld_loading <= 1'b0;
      ld_done    <= 1'b0;
      instr_p1   <= NOP_WORD;
      vld_p1     <= 1'b0;
      fault_p1   <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      case (ld_state)
        ST_RUN: begin
          if (LoadStart) begin
            ld_state   <= ST_LOAD;
            ld_loading <= 1'b1;
            ld_count   <= '0;
            ld_phase   <= '0;
            vld_p1     <= 1'b0;
            fault_p1   <= 1'b0;
            instr_p1   <= NOP_WORD;
          end else if (!Stall) begin
            if (FetchEn) begin
              vld_p1 <= 1'b1;
              if (fault_p0) begin
                instr_p1 <= NOP_WORD;
                fault_p1 <= 1'b1;
              end else begin
                instr_p1 <= mem_p1[rd_idx_p0];
                fault_p1 <= 1'b0;
              end
            end else begin
              vld_p1   <= 1'b0;
              fault_p1 <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (LoadStart) begin
            ld_state   <= ST_RUN;
            ld_loading <= 1'b0;
            ld_done    <= 1'b1;
            ld_phase   <= '0;
          end else if (byte_take_p0) begin
            ld_asm <= wr_word_p0;
            if (ld_phase == LAST_PH) begin
              ld_phase <= '0;
              ld_count <= ld_count + 1'b1;
              if ((ld_count + 1'b1) == FULL_CNT) begin
                ld_state   <= ST_RUN;
                ld_loading <= 1'b0;
                ld_done    <= 1'b1;
              end
            end else begin
              ld_phase <= ld_phase + 1'b1;
            end
          end
        end
        default: begin
          ld_state <= ST_RUN;
        end
      endcase
    end
  end

  assign Instruction = instr_p1;
  assign InstValid   = vld_p1;
  assign AddrFault   = fault_p1;
  assign Loading     = ld_loading;
  assign LoadDone    = ld_done;
  assign LoadCount   = ld_count;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Bench for inst_mem_loadable: two instances (range checking on and off)
// share all inputs; fetch results and LoadDone pulses are checked by
// cycle-tagged scoreboard queues, status outputs by direct checks.
module tb_inst_mem_loadable;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic        FetchEn, Stall, LoadStart, LoadByteValid;
  logic [7:0]  LoadByte;

  logic [31:0] ins0, ins1;
  logic        v0, v1, f0, f1, ld0, ld1, dn0, dn1;
  logic [8:0]  cnt0, cnt1;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct { int cyc; logic [31:0] ins; logic flt; } fexp_t;
  typedef struct { int cyc; logic [8:0] cnt; } dexp_t;
  fexp_t fq0[$], fq1[$];
  dexp_t dq0[$], dq1[$];

  inst_mem_loadable #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NOP_WORD(32'h0), .CHECK_RANGE(1'b1)) dut0 (
    .clk(clk), .reset(reset), .Address(Address), .FetchEn(FetchEn), .Stall(Stall),
    .Instruction(ins0), .InstValid(v0), .AddrFault(f0),
    .LoadStart(LoadStart), .LoadByte(LoadByte), .LoadByteValid(LoadByteValid),
    .Loading(ld0), .LoadDone(dn0), .LoadCount(cnt0));

  inst_mem_loadable #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NOP_WORD(32'h0), .CHECK_RANGE(1'b0)) dut1 (
    .clk(clk), .reset(reset), .Address(Address), .FetchEn(FetchEn), .Stall(Stall),
    .Instruction(ins1), .InstValid(v1), .AddrFault(f1),
    .LoadStart(LoadStart), .LoadByte(LoadByte), .LoadByteValid(LoadByteValid),
    .Loading(ld1), .LoadDone(dn1), .LoadCount(cnt1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mon_fetch(input int id, input logic v, input logic [31:0] ins, input logic flt);
    fexp_t e;
    bit have;
    have = 1'b0;
    if (id == 0) begin
      if (fq0.size() > 0 && fq0[0].cyc == cyc) begin e = fq0.pop_front(); have = 1'b1; end
    end else begin
      if (fq1.size() > 0 && fq1[0].cyc == cyc) begin e = fq1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      n_chk++;
      if (!(v === 1'b1 && ins === e.ins && flt === e.flt)) begin
        n_fail++;
        $display("FAIL fetch%0d cyc %0d: got valid=%b ins=%h fault=%b, expected valid=1 ins=%h fault=%b",
                 id, cyc, v, ins, flt, e.ins, e.flt);
      end
    end else if (v === 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL fetch%0d cyc %0d: got unexpected InstValid=1 ins=%h, expected InstValid=0", id, cyc, ins);
    end
  endtask

  task automatic mon_done(input int id, input logic d, input logic [8:0] cnt);
    dexp_t e;
    bit have;
    have = 1'b0;
    if (id == 0) begin
      if (dq0.size() > 0 && dq0[0].cyc == cyc) begin e = dq0.pop_front(); have = 1'b1; end
    end else begin
      if (dq1.size() > 0 && dq1[0].cyc == cyc) begin e = dq1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      n_chk++;
      if (!(d === 1'b1 && cnt === e.cnt)) begin
        n_fail++;
        $display("FAIL loaddone%0d cyc %0d: got LoadDone=%b LoadCount=%0d, expected LoadDone=1 LoadCount=%0d",
                 id, cyc, d, cnt, e.cnt);
      end
    end else if (d === 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL loaddone%0d cyc %0d: got unexpected LoadDone=1, expected 0", id, cyc);
    end
  endtask

  always @(negedge clk) begin
    mon_fetch(0, v0, ins0, f0);
    mon_fetch(1, v1, ins1, f1);
    mon_done(0, dn0, cnt0);
    mon_done(1, dn1, cnt1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_fetch(input logic [31:0] i0, input logic e0, input logic [31:0] i1, input logic e1);
    fexp_t a, b;
    a.cyc = cyc + 1; a.ins = i0; a.flt = e0;
    b.cyc = cyc + 1; b.ins = i1; b.flt = e1;
    fq0.push_back(a);
    fq1.push_back(b);
  endtask

  task automatic exp_done(input logic [8:0] c);
    dexp_t a;
    a.cyc = cyc + 1; a.cnt = c;
    dq0.push_back(a);
    dq1.push_back(a);
  endtask

  task automatic send_byte(input logic [7:0] b);
    LoadByte = b;
    LoadByteValid = 1'b1;
    tick();
    LoadByteValid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] i0, input logic e0,
                       input logic [31:0] i1, input logic e1);
    Address = a;
    FetchEn = 1'b1;
    exp_fetch(i0, e0, i1, e1);
    tick();
  endtask

  logic [7:0]  prog_a [8] = '{8'h00, 8'h40, 8'h14, 8'h3c, 8'h0c, 8'h00, 8'h94, 8'h22};
  logic [7:0]  prog_b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0]  prog_c [5] = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee};
  logic [31:0] word;

  initial begin
    reset = 1'b0; Address = '0; FetchEn = 1'b0; Stall = 1'b0;
    LoadStart = 1'b0; LoadByte = '0; LoadByteValid = 1'b0;
    repeat (3) tick();
    chk("reset Instruction", ins0, 32'h0);
    chk("reset InstValid", 32'(v0), 32'd0);
    chk("reset AddrFault", 32'(f0), 32'd0);
    chk("reset Loading", 32'(ld0), 32'd0);
    chk("reset LoadCount", 32'(cnt0), 32'd0);
    reset = 1'b1;
    tick();

    // Full-image load: word i = C0DE0000 | i; exits by itself at DEPTH words.
    LoadStart = 1'b1; tick(); LoadStart = 1'b0;
    chk("full load Loading", 32'(ld0), 32'd1);
    for (int i = 0; i < 256; i++) begin
      word = 32'hC0DE0000 | 32'(i);
      for (int b = 0; b < 4; b++) begin
        if (i == 255 && b == 3) exp_done(9'd256);
        send_byte(word[8*b +: 8]);
      end
    end
    chk("full load exit Loading", 32'(ld0), 32'd0);
    chk("full load LoadCount", 32'(cnt0), 32'd256);
    tick();

    // Two-word load terminated by LoadStart, with an idle gap mid-stream.
    LoadStart = 1'b1; tick(); LoadStart = 1'b0;
    chk("load2 Loading", 32'(ld0), 32'd1);
    chk("load2 LoadCount start", 32'(cnt0), 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) tick();
      send_byte(prog_a[k]);
    end
    LoadStart = 1'b1; exp_done(9'd2); tick(); LoadStart = 1'b0;
    chk("load2 exit Loading", 32'(ld0), 32'd0);
    chk("load2 LoadCount", 32'(cnt0), 32'd2);
    tick();

    fetch(32'h0, 32'h3c144000, 1'b0, 32'h3c144000, 1'b0);
    fetch(32'h4, 32'h2294000c, 1'b0, 32'h2294000c, 1'b0);
    Stall = 1'b1;
    for (int s = 0; s < 3; s++) fetch(32'h8, 32'h2294000c, 1'b0, 32'h2294000c, 1'b0);
    Stall = 1'b0;
    fetch(32'h8, 32'hC0DE0002, 1'b0, 32'hC0DE0002, 1'b0);

    // Faults and range checking; the two instances differ only on range.
    fetch(32'h00000402, 32'h0, 1'b1, 32'h0, 1'b1);
    fetch(32'h00000400, 32'h0, 1'b1, 32'h3c144000, 1'b0);
    fetch(32'h80000000, 32'h0, 1'b1, 32'h3c144000, 1'b0);
    fetch(32'h000003fc, 32'hC0DE00FF, 1'b0, 32'hC0DE00FF, 1'b0);
    FetchEn = 1'b0; tick();
    chk("idle AddrFault", 32'(f0), 32'd0);
    chk("idle Instruction hold", ins0, 32'hC0DE00FF);

    // Reset while Instruction holds a real word.
    fetch(32'h0, 32'h3c144000, 1'b0, 32'h3c144000, 1'b0);
    FetchEn = 1'b0; reset = 1'b0; tick(); reset = 1'b1;
    chk("reset2 Instruction", ins0, 32'h0);
    chk("reset2 InstValid", 32'(v0), 32'd0);
    chk("reset2 Loading", 32'(ld0), 32'd0);
    chk("reset2 LoadCount", 32'(cnt0), 32'd0);

    // Load with same-cycle fetch dropped; abort coincident with 7th byte.
    Address = 32'h4; FetchEn = 1'b1; LoadStart = 1'b1; tick(); LoadStart = 1'b0;
    chk("load3 Instruction NOP", ins0, 32'h0);
    chk("load3 Loading", 32'(ld0), 32'd1);
    for (int k = 0; k < 6; k++) send_byte(prog_b[k]);
    LoadStart = 1'b1; LoadByte = 8'h77; LoadByteValid = 1'b1;
    exp_done(9'd1); tick();
    LoadStart = 1'b0; LoadByteValid = 1'b0;
    chk("load3 LoadCount", 32'(cnt0), 32'd1);
    fetch(32'h0, 32'h44332211, 1'b0, 32'h44332211, 1'b0);
    fetch(32'h4, 32'h2294000c, 1'b0, 32'h2294000c, 1'b0);
    FetchEn = 1'b0; tick();

    // Reset after five bytes: first word kept, partial word lost.
    LoadStart = 1'b1; tick(); LoadStart = 1'b0;
    for (int k = 0; k < 5; k++) send_byte(prog_c[k]);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("reset3 Loading", 32'(ld0), 32'd0);
    chk("reset3 LoadCount", 32'(cnt0), 32'd0);
    fetch(32'h0, 32'hddccbbaa, 1'b0, 32'hddccbbaa, 1'b0);
    fetch(32'h4, 32'h2294000c, 1'b0, 32'h2294000c, 1'b0);
    FetchEn = 1'b0;
    repeat (3) tick();

    chk("fetch queue 0 drained", 32'(fq0.size()), 32'd0);
    chk("fetch queue 1 drained", 32'(fq1.size()), 32'd0);
    chk("done queue 0 drained", 32'(dq0.size()), 32'd0);
    chk("done queue 1 drained", 32'(dq1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
